pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It detects load-use hazards that the forwarding unit cannot resolve, freezes the pipeline while the data memory is busy, squashes wrong-path instructions on a taken branch or jump, and traps a hung memory access with a watchdog. It drives the PC and pipeline-register write enables and flushes, and it sits beside the forwarding unit in the ID/EX control path.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 50 +++++
 rtl/hazard_perf_counters.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
//
// Holds the FSM state encoding, the bubble NOP, the forwarding-select codes
// shared with the forwarding unit, the stage-control bundle and the load-use
// detection helper.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    // addi x0, x0, 0 - the canonical RISC-V NOP loaded as a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic pc_wen;
        logic if_id_wen;
        logic id_ex_wen;
        logic ex_mem_wen;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam stage_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // A load result is not available to EX until the load reaches WB, so a
    // consumer directly behind it must wait one cycle. x0 is never a hazard.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// rtl/hazard_perf_counters.sv - stall/flush/wait event counters for the hazard controller
//
// Ports: clk, rst (sync active-high); stall_evt/flush_evt/wait_evt one-cycle
// event strobes; stall_cnt/flush_cnt/wait_cnt free-running CNT_W-bit counts
// that wrap modulo 2^CNT_W.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_evt,
    input  logic             flush_evt,
    input  logic             wait_evt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_evt) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt) flush_cnt <= flush_cnt + CNT_W'(1);
            if (wait_evt)  wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with memory watchdog for the 5-stage pipeline
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds Stall_Cnt/Flush_Cnt/Wait_Cnt).
// Ports: clk, rst (sync active-high); hazard inputs ID_EX_MemRead, Rd_EX,
// Rs1_ID, Rs2_ID, Use_Rs1_ID, Use_Rs2_ID; Branch_Taken_EX; Dmem_Req,
// Dmem_Ready; stage write enables PC_WEN..EX_MEM_WEN; bubble loads
// IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush; sticky Mem_Fault.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       Rd_EX,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             Use_Rs1_ID,
    input  logic             Use_Rs2_ID,
    input  logic             Branch_Taken_EX,
    input  logic             Dmem_Req,
    input  logic             Dmem_Ready,
    output logic             PC_WEN,
    output logic             IF_ID_WEN,
    output logic             ID_EX_WEN,
    output logic             EX_MEM_WEN,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Flush,
    output logic             Mem_Fault
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Wait_Cnt
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MEM_TIMEOUT);

    logic [1:0]        state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    stage_ctrl_t       ctrl;
    logic              run_eval;
    logic              mem_stall;
    logic              hazard;
    logic              stall_evt, flush_evt, wait_evt;

    assign mem_stall = Dmem_Req && !Dmem_Ready;
    assign hazard    = load_use_hazard(ID_EX_MemRead, Rd_EX, Rs1_ID, Rs2_ID,
                                       Use_Rs1_ID, Use_Rs2_ID);

    always_comb begin
        ctrl         = CTRL_NORMAL;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        run_eval     = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        wait_evt     = 1'b0;

        case (state)
            ST_RUN: run_eval = 1'b1;
            ST_MEM_WAIT: begin
                wait_evt = 1'b1;
                if (Dmem_Ready) begin
                    // Release cycle: whatever is waiting in EX/ID is
                    // serviced now instead of costing another cycle.
                    state_nxt = ST_RUN;
                    run_eval  = 1'b1;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt >= WAIT_LIMIT) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                    end
                end
            end
            // FAULT and the unused encoding both hold the pipe until reset
            default: ctrl = CTRL_FREEZE;
        endcase

        if (run_eval) begin
            if (mem_stall) begin
                ctrl         = CTRL_FREEZE;
                state_nxt    = ST_MEM_WAIT;
                wait_cnt_nxt = WCNT_W'(1);
            end else if (Branch_Taken_EX) begin
                // Also covers a simultaneous load-use: the consumer in ID
                // is on the wrong path and gets squashed.
                ctrl      = CTRL_BRANCH;
                flush_evt = 1'b1;
            end else if (hazard) begin
                ctrl      = CTRL_STALL;
                stall_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign PC_WEN       = ctrl.pc_wen;
    assign IF_ID_WEN    = ctrl.if_id_wen;
    assign ID_EX_WEN    = ctrl.id_ex_wen;
    assign EX_MEM_WEN   = ctrl.ex_mem_wen;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Flush  = ctrl.id_ex_flush;
    assign MEM_WB_Flush = ctrl.mem_wb_flush;
    assign Mem_Fault    = (state == ST_FAULT);

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_evt (stall_evt),
        .flush_evt (flush_evt),
        .wait_evt  (wait_evt),
        .stall_cnt (Stall_Cnt),
        .flush_cnt (Flush_Cnt),
        .wait_cnt  (Wait_Cnt)
    );
`else
    logic perf_evt_unused;
    assign perf_evt_unused = stall_evt ^ flush_evt ^ wait_evt;
`endif

endmodule
